countdown_ctrl: RTL and testbench

//  Countdown-timer controller: owns a 1 s prescaler and a seconds register, sequences it through

---
 rtl/countdown_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//
// Countdown-timer controller. Owns a 1 s prescaler and a seconds register and
// sequences them through IDLE / RUN / PAUSE / ALARM from two debounced
// push-button levels. When the count reaches zero the alarm is raised for
// ALARM_SEC seconds.
//
// Parameters
//   FREQ       clk cycles per second (100_000_000 on the board)
//   MAX_SEC    largest loadable preset, in seconds
//   ALARM_SEC  alarm duration, in seconds
//
// Ports (W = $clog2(MAX_SEC+1))
//   clk        in   1  single clock, all logic on posedge
//   rst_n      in   1  synchronous reset, active-low
//   btn_start  in   1  start/stop button level, acts on its rising edge
//   btn_clear  in   1  clear button level, acts on its rising edge
//   set_valid  in   1  load set_value as preset (IDLE only)
//   set_value  in   W  preset in seconds (clamped to MAX_SEC)
//   remain     out  W  seconds remaining
//   running    out  1  high in RUN
//   alarm      out  1  high in ALARM
//   sec_pulse  out  1  one-cycle strobe per 1 s tick in RUN or ALARM
//
// Build option
//   AUTO_RELOAD_EN  when defined, ALARM expiry reloads the preset and returns
//                   to RUN (periodic timer) instead of going to IDLE.
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter  int FREQ      = 10,
  parameter  int MAX_SEC   = 59,
  parameter  int ALARM_SEC = 3,
  localparam int W         = $clog2(MAX_SEC + 1),
  localparam int P         = $clog2(FREQ + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start,
  input  logic         btn_clear,
  input  logic         set_valid,
  input  logic [W-1:0] set_value,
  output logic [W-1:0] remain,
  output logic         running,
  output logic         alarm,
  output logic         sec_pulse
);

  localparam int A = $clog2(ALARM_SEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Registers
  state_t         state_r;
  logic [W-1:0]   remain_r;
  logic [W-1:0]   preset_r;
  logic [P-1:0]   presc_r;
  logic [A-1:0]   acnt_r;
  logic           start_sync_r;
  logic           start_prev_r;
  logic           clear_sync_r;
  logic           clear_prev_r;
  logic           running_r;
  logic           alarm_r;
  logic           sec_pulse_r;

  // Next-state values
  state_t         state_nxt_s;
  logic [W-1:0]   remain_nxt_s;
  logic [W-1:0]   preset_nxt_s;
  logic [P-1:0]   presc_nxt_s;
  logic [A-1:0]   acnt_nxt_s;
  logic           start_rise_s;
  logic           clear_rise_s;
  logic           tick_s;
  logic           counting_s;
  logic [W-1:0]   set_clamped_s;

  // Rising-edge detection on the synchronised button levels
  assign start_rise_s = start_sync_r & ~start_prev_r;
  assign clear_rise_s = clear_sync_r & ~clear_prev_r;

  // The prescaler only runs while counting down or sounding the alarm
  assign counting_s = (state_r == ST_RUN) || (state_r == ST_ALARM);
  assign tick_s     = counting_s && (presc_r == P'(FREQ - 1));

  assign set_clamped_s = (set_value > W'(MAX_SEC)) ? W'(MAX_SEC) : set_value;

  // Next-state logic: clear > tick-to-zero > start > plain tick decrement
  always_comb begin
    state_nxt_s  = state_r;
    remain_nxt_s = remain_r;
    preset_nxt_s = preset_r;
    presc_nxt_s  = presc_r;
    acnt_nxt_s   = acnt_r;

    if (counting_s) begin
      presc_nxt_s = tick_s ? {P{1'b0}} : (presc_r + P'(1));
    end else begin
      presc_nxt_s = presc_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (set_valid) begin
          preset_nxt_s = set_clamped_s;
          remain_nxt_s = set_clamped_s;
        end else begin
          preset_nxt_s = preset_r;
        end
        // Start with a zero count is meaningless and is dropped
        if (start_rise_s && (remain_r != {W{1'b0}})) begin
          state_nxt_s = ST_RUN;
          presc_nxt_s = {P{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (clear_rise_s) begin
          state_nxt_s  = ST_IDLE;
          remain_nxt_s = preset_r;
          presc_nxt_s  = {P{1'b0}};
        end else if (tick_s && (remain_r == W'(1))) begin
          state_nxt_s  = ST_ALARM;
          remain_nxt_s = {W{1'b0}};
          acnt_nxt_s   = {A{1'b0}};
        end else begin
          // A tick coinciding with a start press still takes its decrement
          if (tick_s && (remain_r != {W{1'b0}})) begin
            remain_nxt_s = remain_r - W'(1);
          end else begin
            remain_nxt_s = remain_r;
          end
          if (start_rise_s) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end

      ST_PAUSE: begin
        if (clear_rise_s) begin
          state_nxt_s  = ST_IDLE;
          remain_nxt_s = preset_r;
          presc_nxt_s  = {P{1'b0}};
        end else if (start_rise_s) begin
          // Prescaler keeps its held phase so the partial second is not lost
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end

      ST_ALARM: begin
        if (start_rise_s || clear_rise_s) begin
          state_nxt_s  = ST_IDLE;
          remain_nxt_s = preset_r;
          presc_nxt_s  = {P{1'b0}};
        end else if (tick_s) begin
          if (acnt_r == A'(ALARM_SEC - 1)) begin
            remain_nxt_s = preset_r;
            acnt_nxt_s   = {A{1'b0}};
`ifdef AUTO_RELOAD_EN
            state_nxt_s  = ST_RUN;
`else
            state_nxt_s  = ST_IDLE;
            presc_nxt_s  = {P{1'b0}};
`endif
          end else begin
            acnt_nxt_s = acnt_r + A'(1);
          end
        end else begin
          state_nxt_s = ST_ALARM;
        end
      end

      default: begin
        state_nxt_s  = ST_IDLE;
        remain_nxt_s = {W{1'b0}};
        preset_nxt_s = {W{1'b0}};
        presc_nxt_s  = {P{1'b0}};
        acnt_nxt_s   = {A{1'b0}};
      end
    endcase
  end

  // State, datapath, button synchronisers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      remain_r     <= {W{1'b0}};
      preset_r     <= {W{1'b0}};
      presc_r      <= {P{1'b0}};
      acnt_r       <= {A{1'b0}};
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b0;
      clear_sync_r <= 1'b0;
      clear_prev_r <= 1'b0;
      running_r    <= 1'b0;
      alarm_r      <= 1'b0;
      sec_pulse_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      remain_r     <= remain_nxt_s;
      preset_r     <= preset_nxt_s;
      presc_r      <= presc_nxt_s;
      acnt_r       <= acnt_nxt_s;
      start_sync_r <= btn_start;
      start_prev_r <= start_sync_r;
      clear_sync_r <= btn_clear;
      clear_prev_r <= clear_sync_r;
      // Decoded from the next state so they change together with state_r
      running_r    <= (state_nxt_s == ST_RUN);
      alarm_r      <= (state_nxt_s == ST_ALARM);
      sec_pulse_r  <= tick_s;
    end
  end

  assign remain    = remain_r;
  assign running   = running_r;
  assign alarm     = alarm_r;
  assign sec_pulse = sec_pulse_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//
// Directed scenarios followed by a randomized run. A cycle-level reference
// model built from the timer's behavioural rules (seconds phase counter,
// button edge history, mode) predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

  localparam int FREQ      = 10;
  localparam int MAX_SEC   = 59;
  localparam int ALARM_SEC = 3;
  localparam int W         = $clog2(MAX_SEC + 1);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn_start;
  logic         btn_clear;
  logic         set_valid;
  logic [W-1:0] set_value;
  logic [W-1:0] remain;
  logic         running;
  logic         alarm;
  logic         sec_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode, m_remain, m_preset, m_phase, m_asec;
  bit m_pulse;
  bit s_last, s_prev, c_last, c_prev;

  countdown_ctrl #(.FREQ(FREQ), .MAX_SEC(MAX_SEC), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .set_valid(set_valid), .set_value(set_value), .remain(remain),
    .running(running), .alarm(alarm), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit st, cl, tick, go;
    if (!rst_n) begin
      m_mode = M_IDLE; m_remain = 0; m_preset = 0; m_phase = 0; m_asec = 0;
      m_pulse = 1'b0; s_last = 1'b0; s_prev = 1'b0; c_last = 1'b0; c_prev = 1'b0;
    end else begin
      st   = s_last && !s_prev;
      cl   = c_last && !c_prev;
      tick = (m_mode == M_RUN || m_mode == M_ALARM) && (m_phase == FREQ - 1);
      m_pulse = tick;
      if (m_mode == M_RUN || m_mode == M_ALARM) m_phase = tick ? 0 : m_phase + 1;
      case (m_mode)
        M_IDLE: begin
          go = st && (m_remain != 0);
          if (set_valid) begin
            m_preset = (int'(set_value) > MAX_SEC) ? MAX_SEC : int'(set_value);
            m_remain = m_preset;
          end
          if (go) begin m_mode = M_RUN; m_phase = 0; end
        end
        M_RUN: begin
          if (cl) begin
            m_mode = M_IDLE; m_remain = m_preset; m_phase = 0;
          end else if (tick && m_remain == 1) begin
            m_mode = M_ALARM; m_remain = 0; m_asec = 0;
          end else begin
            if (tick && m_remain > 0) m_remain--;
            if (st) m_mode = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (cl) begin m_mode = M_IDLE; m_remain = m_preset; m_phase = 0; end
          else if (st) m_mode = M_RUN;
        end
        M_ALARM: begin
          if (st || cl) begin
            m_mode = M_IDLE; m_remain = m_preset; m_phase = 0;
          end else if (tick) begin
            m_asec++;
            if (m_asec == ALARM_SEC) begin
              m_remain = m_preset; m_asec = 0;
`ifdef AUTO_RELOAD_EN
              m_mode = M_RUN;
`else
              m_mode = M_IDLE; m_phase = 0;
`endif
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
      s_prev = s_last; s_last = btn_start;
      c_prev = c_last; c_last = btn_clear;
    end
  endtask

  task automatic check_all();
    chk("remain",    32'(remain),    32'(m_remain));
    chk("running",   32'(running),   32'(m_mode == M_RUN));
    chk("alarm",     32'(alarm),     32'(m_mode == M_ALARM));
    chk("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
  endtask

  // One clock: edge, model update, then compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int v);
    set_valid = 1'b1; set_value = W'(v);
    cycle();
    set_valid = 1'b0;
  endtask

  task automatic press_start();
    btn_start = 1'b1; cycles(3); btn_start = 1'b0; cycle();
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; cycles(3); btn_clear = 1'b0; cycle();
  endtask

  initial begin
    int ac;
    rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; set_valid = 1'b0; set_value = '0;

    // T1: reset, then a start press with nothing loaded is ignored
    cycles(2);
    rst_n = 1'b1;
    press_start();
    cycles(3);
    chk("t1_remain", 32'(remain), 32'd0);
    chk("t1_running", 32'(running), 32'd0);
    chk("t1_alarm", 32'(alarm), 32'd0);

    // T2: full countdown from 5 through the alarm
    load(5);
    chk("t2_loaded", 32'(remain), 32'd5);
    btn_start = 1'b1;
    cycle();
    chk("t2_run_edge1", 32'(running), 32'd0);
    cycle();
    chk("t2_run_edge2", 32'(running), 32'd1);
    btn_start = 1'b0;
    cycles(10);
    chk("t2_first_dec", 32'(remain), 32'd4);
    ac = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (alarm) ac++;
      if (ac > 0 && !alarm) break;
    end
    chk("t2_alarm_len", 32'(ac), 32'd30);
    chk("t2_end_remain", 32'(remain), 32'd5);
`ifdef AUTO_RELOAD_EN
    chk("t2_end_running", 32'(running), 32'd1);
`else
    chk("t2_end_running", 32'(running), 32'd0);
`endif
    press_clear();

    // T3: pause after 25 cycles in RUN, then resume mid-second
    load(5);
    btn_start = 1'b1; cycles(2); btn_start = 1'b0;
    cycles(23);
    btn_start = 1'b1; cycles(2); btn_start = 1'b0;
    chk("t3_pause_remain", 32'(remain), 32'd3);
    chk("t3_paused", 32'(running), 32'd0);
    cycles(20);
    chk("t3_held", 32'(remain), 32'd3);
    btn_start = 1'b1; cycles(2); btn_start = 1'b0;
    chk("t3_resumed", 32'(running), 32'd1);
    cycles(4);
    chk("t3_before_dec", 32'(remain), 32'd3);
    cycle();
    chk("t3_dec", 32'(remain), 32'd2);
    chk("t3_pulse", 32'(sec_pulse), 32'd1);
    press_clear();

    // T4: clamp on load, load ignored while running
    load(63);
    chk("t4_clamp", 32'(remain), 32'd59);
    press_start();
    load(10);
    chk("t4_ignored", 32'(remain), 32'd59);

    // T5a: clear and start together in RUN -> IDLE with preset
    btn_start = 1'b1; btn_clear = 1'b1; cycles(2);
    btn_start = 1'b0; btn_clear = 1'b0;
    chk("t5_conflict_run", 32'(running), 32'd0);
    chk("t5_conflict_remain", 32'(remain), 32'd59);
    cycles(2);

    // T5b: tick and start together at remain=2 -> remain=1 and paused
    load(2);
    btn_start = 1'b1; cycles(2); btn_start = 1'b0;
    cycles(8);
    btn_start = 1'b1; cycles(2); btn_start = 1'b0;
    chk("t5_tick_start_remain", 32'(remain), 32'd1);
    chk("t5_tick_start_paused", 32'(running), 32'd0);
    chk("t5_tick_start_alarm", 32'(alarm), 32'd0);
    press_clear();

`ifdef AUTO_RELOAD_EN
    // T6: periodic reload after the alarm
    load(2);
    press_start();
    ac = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (alarm) ac++;
      if (ac > 0 && !alarm) break;
    end
    chk("t6_alarm_len", 32'(ac), 32'd30);
    chk("t6_reload_run", 32'(running), 32'd1);
    chk("t6_reload_remain", 32'(remain), 32'd2);
    press_clear();
    chk("t6_cleared", 32'(running), 32'd0);
`endif

    // Randomized run against the reference model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 149) == 0) btn_clear = ~btn_clear;
      set_valid = ($urandom_range(0, 29) == 0);
      set_value = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 63))
                                               : W'($urandom_range(0, 4));
      rst_n = ($urandom_range(0, 999) != 0);
      cycle();
    end
    rst_n = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; set_valid = 1'b0;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
